wb_grf: RTL and testbench

- Write-back end of the MEM/WB interface: the general-purpose register file (GRF).
- Consumes the registered write-back bundle (PC, write address, write data, write enable) and commits it into 32 x 32-bit registers.
- Serves two decode-stage read ports with same-cycle write-to-read bypass.
- Keeps a retired-write counter for debug and verification.

---
 rtl/wb_grf_pkg.sv | 33 +++
 rtl/grf_read_port.sv | 25 ++
 rtl/wb_grf.sv | 81 ++++++++
 tb/tb_wb_grf.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/wb_grf_pkg.sv
// Shared constants, write-back bundle type and instruction field helpers for the GRF.
// Decode uses the rs/rt/rd helpers so ra1/ra2 are always sliced the same way.
package wb_grf_pkg;

  localparam int unsigned NREG = 32;
  localparam int unsigned DW   = 32;
  localparam int unsigned AW   = 5;
  localparam int unsigned PCW  = 32;
  localparam int unsigned CW   = 32;

  localparam logic [AW-1:0] GRF_ZERO = AW'(0);

  // Registered MEM/WB payload as seen by the write-back end
  typedef struct packed {
    logic [PCW-1:0] pc;
    logic [AW-1:0]  wa;
    logic [DW-1:0]  wd;
    logic           regwrite;
  } wb_bundle_t;

  function automatic logic [AW-1:0] instr_rs(input logic [31:0] instr);
    return instr[25:21];
  endfunction

  function automatic logic [AW-1:0] instr_rt(input logic [31:0] instr);
    return instr[20:16];
  endfunction

  function automatic logic [AW-1:0] instr_rd(input logic [31:0] instr);
    return instr[15:11];
  endfunction

endpackage

// File: rtl/grf_read_port.sv
// One GRF read port: reset/zero-register mask, then write-back bypass, then storage.
module grf_read_port
  import wb_grf_pkg::*;
(
  input  logic          reset,
  input  logic [AW-1:0] ra,
  input  logic          wb_regwrite,
  input  logic [AW-1:0] wb_wa,
  input  logic [DW-1:0] wb_wd,
  input  logic [DW-1:0] store_data,
  output logic [DW-1:0] rd_c
);

  always_comb begin
    rd_c = '0;
    if (reset || ra == GRF_ZERO) begin
      rd_c = '0;
    end else if (wb_regwrite && wb_wa == ra) begin
      rd_c = wb_wd;
    end else begin
      rd_c = store_data;
    end
  end

endmodule

// File: rtl/wb_grf.sv
// Write-back general-purpose register file: 32x32 storage, two bypassed read ports,
// retired-write counter. Define GRF_TRACE_EN for a simulation trace of each write-back.
module wb_grf
  import wb_grf_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic [PCW-1:0] wb_pc,
  input  logic [AW-1:0]  wb_wa,
  input  logic [DW-1:0]  wb_wd,
  input  logic           wb_regwrite,
  input  logic [AW-1:0]  ra1,
  input  logic [AW-1:0]  ra2,
  output logic [DW-1:0]  rd1,
  output logic [DW-1:0]  rd2,
  output logic [CW-1:0]  wr_count
);

  wb_bundle_t     wb;
  logic           wr_eff_c;
  logic [DW-1:0]  regs [NREG];
  logic [CW-1:0]  cnt_q;

  assign wb = '{pc: wb_pc, wa: wb_wa, wd: wb_wd, regwrite: wb_regwrite};

  // Writes to $0 are dropped and not counted
  assign wr_eff_c = wb.regwrite && (wb.wa != GRF_ZERO);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(NREG); i++) begin
        regs[i] <= '0;
      end
    end else if (wr_eff_c) begin
      regs[wb.wa] <= wb.wd;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (wr_eff_c) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign wr_count = cnt_q;

  grf_read_port u_port1 (
    .reset       (reset),
    .ra          (ra1),
    .wb_regwrite (wb.regwrite),
    .wb_wa       (wb.wa),
    .wb_wd       (wb.wd),
    .store_data  (regs[ra1]),
    .rd_c        (rd1)
  );

  grf_read_port u_port2 (
    .reset       (reset),
    .ra          (ra2),
    .wb_regwrite (wb.regwrite),
    .wb_wa       (wb.wa),
    .wb_wd       (wb.wd),
    .store_data  (regs[ra2]),
    .rd_c        (rd2)
  );

`ifdef GRF_TRACE_EN
  // Trace every requested write-back, including ones aimed at $0
  always @(posedge clk) begin
    if (!reset && wb.regwrite) begin
      $display("%d@%h: $%d <= %h", $time, wb.pc, wb.wa, wb.wd);
    end
  end
`else
  logic unused_pc;
  assign unused_pc = ^wb.pc;
`endif

endmodule

// File: tb/tb_wb_grf.sv
// Scoreboard bench for wb_grf: driver pushes expected reads/count, monitor compares.
module tb_wb_grf;
  import wb_grf_pkg::*;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [31:0]    wb_pc = '0;
  logic [4:0]     wb_wa = '0;
  logic [31:0]    wb_wd = '0;
  logic           wb_regwrite = 1'b0;
  logic [4:0]     ra1 = '0;
  logic [4:0]     ra2 = '0;
  logic [31:0]    rd1, rd2, wr_count;

  wb_grf dut (
    .clk         (clk),
    .reset       (reset),
    .wb_pc       (wb_pc),
    .wb_wa       (wb_wa),
    .wb_wd       (wb_wd),
    .wb_regwrite (wb_regwrite),
    .ra1         (ra1),
    .ra2         (ra2),
    .rd1         (rd1),
    .rd2         (rd2),
    .wr_count    (wr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          step;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] m_reg [32];
  logic [31:0] m_cnt;
  int          checks = 0;
  int          failures = 0;
  int          step_no = 0;

  // Architectural read rule: reset -> 0, $0 -> 0, matching write-back -> wd, else storage
  function automatic logic [31:0] model_rd(input logic rst, input logic we,
                                           input logic [4:0] wa, input logic [31:0] wd,
                                           input logic [4:0] ra);
    if (rst || ra == 5'd0) return 32'd0;
    if (we && wa == ra) return wd;
    return m_reg[ra];
  endfunction

  task automatic step(input logic rst, input logic we, input logic [4:0] wa,
                      input logic [31:0] wd, input logic [4:0] r1, input logic [4:0] r2);
    exp_t e;
    @(negedge clk);
    reset = rst; wb_regwrite = we; wb_wa = wa; wb_wd = wd; ra1 = r1; ra2 = r2;
    wb_pc = wb_pc + 32'd4;
    if (rst) begin
      for (int i = 0; i < 32; i++) m_reg[i] = '0;
      m_cnt = '0;
    end
    e.step = step_no;
    e.rd1  = model_rd(rst, we, wa, wd, r1);
    e.rd2  = model_rd(rst, we, wa, wd, r2);
    e.cnt  = m_cnt;
    sb_q.push_back(e);
    step_no++;
    if (!rst && we && wa != 5'd0) begin
      m_reg[wa] = wd;
      m_cnt = m_cnt + 32'd1;
    end
  endtask

  // Monitor: outputs are combinational, sampled well after the driver's negedge update
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        checks++;
        if (rd1 !== e.rd1) begin
          failures++;
          $display("FAIL rd1 step=%0d ra1=%0d got=%h exp=%h", e.step, ra1, rd1, e.rd1);
        end
        checks++;
        if (rd2 !== e.rd2) begin
          failures++;
          $display("FAIL rd2 step=%0d ra2=%0d got=%h exp=%h", e.step, ra2, rd2, e.rd2);
        end
        checks++;
        if (wr_count !== e.cnt) begin
          failures++;
          $display("FAIL wr_count step=%0d got=%h exp=%h", e.step, wr_count, e.cnt);
        end
      end
    end
  end

  initial begin
    logic [4:0]  xa;
    logic [4:0]  wa, r1, r2;
    logic        we, rst;
    for (int i = 0; i < 32; i++) m_reg[i] = '0;
    m_cnt = '0;

    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 7, 32'h1234, 7, 0);          // write during reset is lost
    step(0, 0, 0, 0, 7, 0);

    // basic write then read back
    step(0, 1, 8, 32'hDEADBEEF, 0, 0);
    step(0, 0, 8, 0, 8, 8);

    // same-cycle bypass on both ports, then storage after the edge
    step(0, 1, 9, 32'h1, 0, 0);
    step(0, 1, 9, 32'h2, 9, 9);
    step(0, 0, 0, 0, 9, 8);

    // $0 protection
    step(0, 1, 0, 32'hFFFFFFFF, 0, 0);
    step(0, 0, 0, 0, 0, 9);

    // disabled write
    step(0, 1, 3, 32'hAA, 0, 0);
    step(0, 0, 3, 32'h55, 3, 3);
    step(0, 0, 0, 0, 3, 0);

    // X address with write disabled
    xa = 'x;
    step(0, 0, xa, 32'h77, 3, 8);

    // counter wrap: preload the counter, then one effective write
    @(negedge clk);
    dut.cnt_q <= 32'hFFFFFFFF;
    m_cnt = 32'hFFFFFFFF;
    step(0, 1, 4, 32'hCAFEF00D, 0, 0);
    step(0, 0, 0, 0, 4, 4);

    // mid-run reset after writes to $5 and $31
    step(0, 1, 5, 32'h5555, 0, 0);
    step(0, 1, 31, 32'h3131, 5, 0);
    step(0, 0, 0, 0, 5, 31);
    step(1, 0, 0, 0, 5, 31);
    step(0, 0, 0, 0, 5, 31);

    // randomized traffic with occasional resets and deliberate address collisions
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 49) == 0);
      we  = $urandom_range(0, 2) != 0;
      wa  = 5'($urandom_range(0, 31));
      r1  = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      r2  = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      step(rst, we, wa, $urandom, r1, r2);
    end

    step(0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    #4;
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d exp=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
